multi_dir_traffic_ctrl: RTL

MULTI_DIR_TRAFFIC_CTRL -- requirements
Module: multi_dir_traffic_ctrl

---
 rtl/multi_dir_traffic_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multi_dir_traffic_ctrl.sv
// Round-robin traffic light controller: ALL_RED -> GREEN -> YELLOW per direction.
// Define TL_PED_EN to latch pedestrian calls and extend the served green with a walk.
module multi_dir_traffic_ctrl #(
  parameter int NUM_DIR       = 2,
  parameter int GREEN_CYC     = 8,
  parameter int YELLOW_CYC    = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int PED_EXTRA_CYC = 4,
  parameter int CNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DIR-1:0]         ped_req,
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [NUM_DIR-1:0]         ped_walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int DIR_W = $clog2(NUM_DIR);

  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] GX_LAST = CNT_W'(GREEN_CYC + PED_EXTRA_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYC - 1);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic                 ext_q, ext_d;
  logic [3*NUM_DIR-1:0] lights_q, lights_d;
  logic [NUM_DIR-1:0]   ped_walk_q, ped_walk_d;
  logic                 enter_green;
  logic                 ped_hit;

  assign enter_green = (state_q == S_ALL_RED) && (cnt_q == AR_LAST);

`ifdef TL_PED_EN
  logic [NUM_DIR-1:0] pending_q, pending_d;

  // A call present on the green-entry edge itself is served by that green.
  always_comb begin
    pending_d = pending_q | ped_req;
    ped_hit   = pending_d[dir_q];
    if (enter_green) pending_d[dir_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ^ped_req;
  assign ped_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dir_d   = dir_q;
    ext_d   = ext_q;
    case (state_q)
      S_ALL_RED: if (enter_green) begin
        state_d = S_GREEN;
        cnt_d   = '0;
        ext_d   = ped_hit;
      end
      S_GREEN: if (cnt_q == (ext_q ? GX_LAST : G_LAST)) begin
        state_d = S_YELLOW;
        cnt_d   = '0;
        ext_d   = 1'b0;
      end
      S_YELLOW: if (cnt_q == Y_LAST) begin
        state_d = S_ALL_RED;
        cnt_d   = '0;
        dir_d   = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
      end
      default: begin
        state_d = S_ALL_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the transition edge.
  always_comb begin
    lights_d   = '0;
    ped_walk_d = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      lights_d[3*i +: 3] = 3'b100;
      if (i == int'(dir_d)) begin
        if (state_d == S_GREEN) begin
          lights_d[3*i +: 3] = 3'b001;
          ped_walk_d[i]      = ext_d;
        end else if (state_d == S_YELLOW) begin
          lights_d[3*i +: 3] = 3'b010;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_ALL_RED;
      cnt_q      <= '0;
      dir_q      <= '0;
      ext_q      <= 1'b0;
      lights_q   <= {NUM_DIR{3'b100}};
      ped_walk_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      ext_q      <= ext_d;
      lights_q   <= lights_d;
      ped_walk_q <= ped_walk_d;
    end
  end

  assign lights     = lights_q;
  assign ped_walk   = ped_walk_q;
  assign active_dir = dir_q;

endmodule
